// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - register file writeback: load queue, load formatting, ALU skid, write arbitration
module wb_unit #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        reg_write,
  output logic [4:0]  Instruction_rd,
  output logic [31:0] write_data_reg_file,
  output logic [31:0] pending_mask,
  output logic        err
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  logic [4:0]    q_rd [LQ_DEPTH];
  logic [2:0]    q_f3 [LQ_DEPTH];
  logic [1:0]    q_lo [LQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          skid_valid;
  logic [4:0]    skid_rd;
  logic [31:0]   skid_data;

  logic          push, pop, alu_acc, q_empty, bad_f3;
  logic [4:0]    head_rd;
  logic [2:0]    head_f3;
  logic [1:0]    head_lo;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_empty   = (count == '0);
  assign ld_ready  = (count != CW'(LQ_DEPTH));
  assign alu_ready = !skid_valid;
  assign push      = ld_valid && ld_ready;
  assign pop       = mem_rvalid && !q_empty;
  assign alu_acc   = alu_valid && alu_ready;
  assign head_rd   = q_rd[rd_ptr];
  assign head_f3   = q_f3[rd_ptr];
  assign head_lo   = q_lo[rd_ptr];

  always_comb begin
    byte_sel = 8'(mem_rdata >> {head_lo, 3'b000});
    half_sel = head_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data  = '0;
    bad_f3   = 1'b0;
    case (head_f3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      3'b010:  ld_data = mem_rdata;
      default: bad_f3  = 1'b1;
    endcase
  end

  // Walk the live entries from the head; x0 never blocks decode.
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < LQ_DEPTH; k++) begin
      if (CW'(k) < count)
        pending_mask[q_rd[PW'((int'(rd_ptr) + k) % LQ_DEPTH)]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr] <= ld_rd;
      q_f3[wr_ptr] <= ld_funct3;
      q_lo[wr_ptr] <= ld_addr_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      skid_valid          <= 1'b0;
      skid_rd             <= '0;
      skid_data           <= '0;
      reg_write           <= 1'b0;
      Instruction_rd      <= '0;
      write_data_reg_file <= '0;
      err                 <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      reg_write <= 1'b0;
      // Load responses cannot be stalled, so they always win the port.
      if (pop) begin
        reg_write           <= (head_rd != 5'd0);
        Instruction_rd      <= head_rd;
        write_data_reg_file <= ld_data;
        if (alu_acc) begin
          skid_valid <= 1'b1;
          skid_rd    <= alu_rd;
          skid_data  <= alu_data;
        end
      end else if (skid_valid) begin
        reg_write           <= (skid_rd != 5'd0);
        Instruction_rd      <= skid_rd;
        write_data_reg_file <= skid_data;
        skid_valid          <= 1'b0;
      end else if (alu_acc) begin
        reg_write           <= (alu_rd != 5'd0);
        Instruction_rd      <= alu_rd;
        write_data_reg_file <= alu_data;
      end

      if ((mem_rvalid && q_empty) || (pop && bad_f3)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed self-checking bench for wb_unit
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, mem_rvalid;
  logic        alu_ready, ld_ready, reg_write, err;
  logic [4:0]  alu_rd, ld_rd, Instruction_rd;
  logic [31:0] alu_data, mem_rdata, write_data_reg_file, pending_mask;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;

  int vectors = 0;
  int miscompares = 0;

  wb_unit #(.LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_write(reg_write), .Instruction_rd(Instruction_rd),
    .write_data_reg_file(write_data_reg_file), .pending_mask(pending_mask), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; mem_rvalid = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    ld_valid = 1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_we"}, reg_write, 1);
    chk({tag, "_rd"}, Instruction_rd, rd);
    chk({tag, "_data"}, write_data_reg_file, data);
  endtask

  initial begin
    rst = 1; idle();
    alu_rd = 0; alu_data = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; mem_rdata = 0;
    #2;
    chk("rst_we", reg_write, 0);
    chk("rst_rd", Instruction_rd, 0);
    chk("rst_data", write_data_reg_file, 0);
    chk("rst_pend", pending_mask, 0);
    chk("rst_alu_rdy", alu_ready, 1);
    chk("rst_ld_rdy", ld_ready, 1);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 0;

    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
    step(); idle();
    expect_write("alu1", 5, 32'h1234_5678);
    step();
    chk("alu1_off", reg_write, 0);

    // load formats: LB lo=3 -> x7, LHU lo=2 -> x8, LW -> x9
    issue(7, 3'b000, 2'd3);
    step();
    chk("lf_pend7", pending_mask, 32'h0000_0080);
    issue(8, 3'b101, 2'd2);
    step(); idle();
    chk("lf_pend78", pending_mask, 32'h0000_0180);
    chk("lf_full", ld_ready, 0);
    mem_rvalid = 1; mem_rdata = 32'h80FF_7F01;
    step();
    expect_write("lb", 7, 32'hFFFF_FF80);
    chk("lb_pend", pending_mask, 32'h0000_0100);
    chk("lb_ldrdy", ld_ready, 1);
    issue(9, 3'b010, 2'd1);
    step(); ld_valid = 0;
    expect_write("lhu", 8, 32'h0000_80FF);
    chk("lhu_pend", pending_mask, 32'h0000_0200);
    step(); idle();
    expect_write("lw", 9, 32'h80FF_7F01);
    chk("lw_pend", pending_mask, 0);

    // full queue: simultaneous pop and push attempt must reject the push
    issue(10, 3'b010, 2'd0);
    step();
    issue(11, 3'b010, 2'd0);
    step();
    chk("qf_rdy", ld_ready, 0);
    issue(12, 3'b010, 2'd0); mem_rvalid = 1; mem_rdata = 32'hCAFE_0010;
    step(); ld_valid = 0;
    expect_write("qf_pop1", 10, 32'hCAFE_0010);
    chk("qf_rdy_after", ld_ready, 1);
    chk("qf_pend", pending_mask, 32'h0000_0800);
    mem_rdata = 32'hCAFE_0011;
    step(); idle();
    expect_write("qf_pop2", 11, 32'hCAFE_0011);
    chk("qf_empty", pending_mask, 0);

    // collision: load response beats ALU, ALU lands from skid next cycle
    issue(4, 3'b010, 2'd0);
    step(); ld_valid = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_000A;
    step(); idle();
    expect_write("col_ld", 4, 32'hDEAD_BEEF);
    chk("col_skid_full", alu_ready, 0);
    step();
    expect_write("col_alu", 3, 32'h0000_000A);
    chk("col_skid_free", alu_ready, 1);

    // rd=0 ALU write is suppressed
    alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
    step(); idle();
    chk("rd0_we", reg_write, 0);

    // response with empty queue
    mem_rvalid = 1; mem_rdata = 32'h1111_1111;
    step(); idle();
    chk("empty_we", reg_write, 0);
    chk("empty_err", err, 1);

    // async reset with a load queued and the skid full
    issue(13, 3'b010, 2'd0);
    step();
    issue(14, 3'b010, 2'd0);
    step(); ld_valid = 0;
    mem_rvalid = 1; mem_rdata = 32'h2222_2222;
    alu_valid = 1; alu_rd = 15; alu_data = 32'h3333_3333;
    step(); idle();
    chk("pre_rst_skid", alu_ready, 0);
    chk("pre_rst_pend", pending_mask, 32'h0000_4000);
    #2 rst = 1;
    #1;
    chk("arst_pend", pending_mask, 0);
    chk("arst_alu_rdy", alu_ready, 1);
    chk("arst_ld_rdy", ld_ready, 1);
    chk("arst_we", reg_write, 0);
    chk("arst_err", err, 0);
    @(negedge clk); rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h4444_4444;
    step(); idle();
    chk("post_rst_we", reg_write, 0);
    chk("post_rst_err", err, 1);
    step();
    chk("post_rst_noskid", reg_write, 0);

    // illegal funct3 writes zero and sets err
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    issue(6, 3'b011, 2'd0);
    step(); ld_valid = 0;
    chk("bad_err0", err, 0);
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    step(); idle();
    expect_write("bad_f3", 6, 32'h0);
    chk("bad_err1", err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
